// File: rtl/jk_mode_counter.sv
// Falling-edge counter built from per-bit JK cells with hold, modulo up/down,
// Gray-code up, parallel load and a cascadable terminal-count output.
module jk_mode_counter #(
   parameter int WIDTH = 3,
   parameter int MOD   = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic             tc
);

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_UP   = 2'b01,
      MODE_DOWN = 2'b10,
      MODE_GRAY = 2'b11
   } mode_e;

   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
   localparam logic [WIDTH-1:0] LAST_G = ONE_V << (WIDTH - 1);

   mode_e            mode_s;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] bin_v;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   assign mode_s = mode_e'(mode);

   // NOTE: every variable written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      nxt   = q_q;
      bin_v = '0;
      if (load) begin
         nxt = din;
      end else if (en) begin
         case (mode_s)
            MODE_UP: begin
               // q >= MOD-1 covers both the wrap and any out-of-range value.
               if (q_q >= MAX_V) nxt = '0;
               else              nxt = q_q + ONE_V;
            end
            MODE_DOWN: begin
               if (q_q == '0 || q_q > MAX_V) nxt = MAX_V;
               else                          nxt = q_q - ONE_V;
            end
            MODE_GRAY: begin
               bin_v = gray2bin(q_q) + ONE_V;
               nxt   = bin2gray(bin_v);
            end
            default: nxt = q_q;
         endcase
      end
   end

   // JK excitation from the desired next state, then the JK characteristic
   // equation per bit: q+ = J & ~q | ~K & q.
   always_comb begin
      j   = ~q_q & nxt;
      k   = q_q & ~nxt;
      q_d = (j & ~q_q) | (~k & q_q);
   end

   // NOTE: sequential state uses non-blocking assignments so every cell
   // samples the pre-edge value of q_q.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) q_q <= '0;
      else        q_q <= q_d;
   end

   always_comb begin
      tc = 1'b0;
      if (en) begin
         case (mode_s)
            MODE_UP:   tc = (q_q == MAX_V);
            MODE_DOWN: tc = (q_q == '0);
            MODE_GRAY: tc = (q_q == LAST_G);
            default:   tc = 1'b0;
         endcase
      end
   end

   assign q = q_q;

endmodule

// File: tb/tb_jk_mode_counter.sv
// Scoreboard bench: stimulus pushes the expected q/tc for each cycle, a monitor
// on the non-active (rising) edge pops and compares.
module tb_jk_mode_counter;

   typedef struct {
      logic [2:0] q;
      logic       tc;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       en;
   logic [1:0] mode;
   logic       load;
   logic [2:0] din;
   logic [2:0] q;
   logic       tc;
   logic       chk;

   exp_t sb[$];
   int   n_cmp;
   int   n_bad;

   jk_mode_counter #(.WIDTH(3), .MOD(6)) dut (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .mode (mode),
      .load (load),
      .din  (din),
      .q    (q),
      .tc   (tc)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Inputs change just after a falling edge, so a reset drop here lands
   // between edges; the expected entry describes the state seen mid-cycle.
   task automatic step(input logic r, input logic e, input logic [1:0] m,
                       input logic l, input logic [2:0] d,
                       input logic [2:0] q_exp, input logic tc_exp);
      exp_t x;
      @(negedge clk);
      #1;
      reset = r;
      en    = e;
      mode  = m;
      load  = l;
      din   = d;
      chk   = 1'b1;
      x.q   = q_exp;
      x.tc  = tc_exp;
      sb.push_back(x);
   endtask

   always @(posedge clk) begin
      if (chk) begin
         if (sb.size() == 0) begin
            check("scoreboard_underflow", 1, 0);
         end else begin
            exp_t x;
            x = sb.pop_front();
            check("q", int'(q), int'(x.q));
            check("tc", int'(tc), int'(x.tc));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      chk   = 1'b0;
      reset = 1'b0;
      en    = 1'b0;
      mode  = 2'b00;
      load  = 1'b0;
      din   = 3'd0;

      // reset state
      step(0, 0, 2'b00, 0, 0, 3'd0, 0);
      // up count from reset, wrap at 5
      step(1, 1, 2'b01, 0, 0, 3'd0, 0);
      step(1, 1, 2'b01, 0, 0, 3'd1, 0);
      step(1, 1, 2'b01, 0, 0, 3'd2, 0);
      step(1, 1, 2'b01, 0, 0, 3'd3, 0);
      step(1, 1, 2'b01, 0, 0, 3'd4, 0);
      step(1, 1, 2'b01, 0, 0, 3'd5, 1);
      step(1, 1, 2'b01, 0, 0, 3'd0, 0);
      step(1, 1, 2'b01, 0, 0, 3'd1, 0);
      // load 0, then down count with wrap to 5
      step(1, 1, 2'b01, 1, 0, 3'd2, 0);
      step(1, 1, 2'b10, 0, 0, 3'd0, 1);
      step(1, 1, 2'b10, 0, 0, 3'd5, 0);
      step(1, 1, 2'b10, 0, 0, 3'd4, 0);
      step(1, 1, 2'b10, 0, 0, 3'd3, 0);
      step(1, 1, 2'b10, 0, 0, 3'd2, 0);
      step(1, 1, 2'b10, 0, 0, 3'd1, 0);
      step(1, 1, 2'b10, 0, 0, 3'd0, 1);
      step(1, 1, 2'b10, 0, 0, 3'd5, 0);
      // out-of-range load: up recovers to 0, down recovers to MOD-1
      step(1, 1, 2'b01, 1, 7, 3'd4, 0);
      step(1, 1, 2'b01, 0, 0, 3'd7, 0);
      step(1, 1, 2'b10, 1, 7, 3'd0, 1);
      step(1, 1, 2'b10, 0, 0, 3'd7, 0);
      // Gray sequence over the full range
      step(1, 1, 2'b11, 1, 0, 3'd5, 0);
      step(1, 1, 2'b11, 0, 0, 3'b000, 0);
      step(1, 1, 2'b11, 0, 0, 3'b001, 0);
      step(1, 1, 2'b11, 0, 0, 3'b011, 0);
      step(1, 1, 2'b11, 0, 0, 3'b010, 0);
      step(1, 1, 2'b11, 0, 0, 3'b110, 0);
      step(1, 1, 2'b11, 0, 0, 3'b111, 0);
      step(1, 1, 2'b11, 0, 0, 3'b101, 0);
      step(1, 1, 2'b11, 0, 0, 3'b100, 1);
      step(1, 1, 2'b11, 0, 0, 3'b000, 0);
      // hold with en=0, then load priority
      for (int i = 0; i < 5; i++) step(1, 0, 2'b01, 0, 0, 3'd1, 0);
      step(1, 0, 2'b01, 1, 3, 3'd1, 0);
      step(1, 1, 2'b01, 1, 2, 3'd3, 0);
      step(1, 1, 2'b00, 0, 0, 3'd2, 0);
      // async reset between edges, held across edges, then resume
      step(1, 0, 2'b00, 1, 4, 3'd2, 0);
      step(1, 0, 2'b01, 0, 0, 3'd4, 0);
      step(0, 1, 2'b01, 0, 0, 3'd0, 0);
      step(0, 1, 2'b01, 0, 0, 3'd0, 0);
      step(0, 1, 2'b10, 0, 0, 3'd0, 1);
      step(1, 1, 2'b01, 0, 0, 3'd0, 0);
      step(1, 1, 2'b01, 0, 0, 3'd1, 0);
      step(1, 0, 2'b00, 0, 0, 3'd2, 0);

      @(negedge clk);
      #1;
      chk = 1'b0;
      @(posedge clk);
      #1;
      check("scoreboard_leftover", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
